// File: rtl/rvm_mem_if_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rvm_mem_if_pkg
// Purpose  : Shared types and constants for the rvm_mem_if memory adapter:
//            FSM state encoding, state-register width, access size codes
//            and small decode helpers used by the align logic.
// Options  : RVM_MEM_TIMEOUT_EN (consumed by rvm_mem_if, not here)
// Revision : 1.0 - initial release
// ============================================================================
package rvm_mem_if_pkg;

  localparam int RVM_MEM_STATE_W = 2;
  localparam int RVM_MEM_TO_W    = 16;

  typedef enum logic [RVM_MEM_STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  localparam logic [1:0] RVM_MEM_SIZE_B = 2'b00;
  localparam logic [1:0] RVM_MEM_SIZE_H = 2'b01;
  localparam logic [1:0] RVM_MEM_SIZE_W = 2'b10;

  // Byte lanes touched by an access of the given size at offset 0.
  function automatic logic [3:0] size_lanes(input logic [1:0] size);
    case (size)
      RVM_MEM_SIZE_B: size_lanes = 4'b0001;
      RVM_MEM_SIZE_H: size_lanes = 4'b0011;
      RVM_MEM_SIZE_W: size_lanes = 4'b1111;
      default:        size_lanes = 4'b0000;
    endcase
  endfunction

  // Illegal size code, or an address not naturally aligned to the size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      RVM_MEM_SIZE_B: is_misaligned = 1'b0;
      RVM_MEM_SIZE_H: is_misaligned = off[0];
      RVM_MEM_SIZE_W: is_misaligned = (off != 2'b00);
      default:        is_misaligned = 1'b1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/rvm_mem_align.sv
`default_nettype none
// ============================================================================
// Module   : rvm_mem_align
// Purpose  : Purely combinational lane logic for rvm_mem_if.
//            Store side: lane replication, byte enables, misalignment check.
//            Load side : shift raw word down by the byte offset, then zero-
//                        or sign-extend byte/half results.
// Ports    : st_off/st_size/st_wdata  -> st_wdata_rep, st_ben, st_misaligned
//            ld_off/ld_size/ld_signed/ld_word -> ld_data
// Revision : 1.0 - initial release
// ============================================================================
module rvm_mem_align
  import rvm_mem_if_pkg::*;
(
  input  logic [1:0]  st_off,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_wdata,
  output logic [31:0] st_wdata_rep,
  output logic [3:0]  st_ben,
  output logic        st_misaligned,
  input  logic [1:0]  ld_off,
  input  logic [1:0]  ld_size,
  input  logic        ld_signed,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shift;

  always_comb begin
    st_wdata_rep = st_wdata;
    case (st_size)
      RVM_MEM_SIZE_B: st_wdata_rep = {4{st_wdata[7:0]}};
      RVM_MEM_SIZE_H: st_wdata_rep = {2{st_wdata[15:0]}};
      default:        st_wdata_rep = st_wdata;
    endcase
    st_ben        = size_lanes(st_size) << st_off;
    st_misaligned = is_misaligned(st_size, st_off);
  end

  always_comb begin
    ld_shift = ld_word >> {ld_off, 3'b000};
    ld_data  = ld_shift;
    case (ld_size)
      RVM_MEM_SIZE_B: ld_data = {{24{ld_signed & ld_shift[7]}}, ld_shift[7:0]};
      RVM_MEM_SIZE_H: ld_data = {{16{ld_signed & ld_shift[15]}}, ld_shift[15:0]};
      default:        ld_data = ld_shift;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rvm_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : rvm_mem_if
// Purpose  : Load/store/fetch adapter between the rvm_control FSM and a
//            request/grant/response memory bus. One access at a time;
//            misaligned/illegal requests complete with error and no bus
//            activity, so the controller always sees one ready pulse.
// Ports    : clk, resetn (async, active low)
//            ctrl_mem_*  : controller request / completion side
//            mem_*       : external bus side (all outputs registered)
// Options  : RVM_MEM_TIMEOUT_EN - abort an access after TIMEOUT_CYCLES
//            cycles in REQ+RSP; otherwise the block waits indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module rvm_mem_if
  import rvm_mem_if_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ctrl_mem_req,
  input  logic        ctrl_mem_wen,
  input  logic [31:0] ctrl_mem_addr,
  input  logic [31:0] ctrl_mem_wdata,
  input  logic [1:0]  ctrl_mem_size,
  input  logic        ctrl_mem_signed,
  output logic        ctrl_mem_ready,
  output logic [31:0] ctrl_mem_rdata,
  output logic        ctrl_mem_error,
  output logic        ctrl_mem_busy,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_ben,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_timeout_range_chk
    $error("rvm_mem_if: TIMEOUT_CYCLES must be in 1..65535");
  end

  mem_state_e  state, state_nx;

  logic [31:0] st_wdata_rep;
  logic [3:0]  st_ben;
  logic        st_misaligned;
  logic [31:0] ld_data;

  // Captured request attributes needed after the bus transfer.
  logic [1:0]  acc_off;
  logic [1:0]  acc_size;
  logic        acc_signed;
  logic        acc_err;
  logic [31:0] raw_rdata;

  logic        timeout_hit;

  rvm_mem_align u_align (
    .st_off        (ctrl_mem_addr[1:0]),
    .st_size       (ctrl_mem_size),
    .st_wdata      (ctrl_mem_wdata),
    .st_wdata_rep  (st_wdata_rep),
    .st_ben        (st_ben),
    .st_misaligned (st_misaligned),
    .ld_off        (acc_off),
    .ld_size       (acc_size),
    .ld_signed     (acc_signed),
    .ld_word       (raw_rdata),
    .ld_data       (ld_data)
  );

`ifdef RVM_MEM_TIMEOUT_EN
  localparam logic [RVM_MEM_TO_W-1:0] TO_LAST = RVM_MEM_TO_W'(TIMEOUT_CYCLES - 1);

  // Counts completed REQ/RSP cycles; the abort fires on the cycle whose
  // edge would bring the count to TIMEOUT_CYCLES.
  logic [RVM_MEM_TO_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      to_cnt <= '0;
    end else if (state == ST_IDLE) begin
      to_cnt <= '0;
    end else if ((state == ST_REQ) || (state == ST_RSP)) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout_hit = ((state == ST_REQ) || (state == ST_RSP)) && (to_cnt == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (ctrl_mem_req) state_nx = st_misaligned ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        if (timeout_hit)  state_nx = ST_DONE;
        else if (mem_gnt) state_nx = ST_RSP;
      end
      ST_RSP: begin
        // rvalid is only honoured here, so early/stray responses are dropped.
        if (timeout_hit || mem_rvalid) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign ctrl_mem_busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_req        <= 1'b0;
      mem_wen        <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_ben        <= '0;
      acc_off        <= '0;
      acc_size       <= '0;
      acc_signed     <= 1'b0;
      acc_err        <= 1'b0;
      raw_rdata      <= '0;
      ctrl_mem_ready <= 1'b0;
      ctrl_mem_rdata <= '0;
      ctrl_mem_error <= 1'b0;
    end else begin
      ctrl_mem_ready <= 1'b0;
      ctrl_mem_rdata <= '0;
      ctrl_mem_error <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (ctrl_mem_req) begin
            mem_req    <= ~st_misaligned;
            mem_wen    <= ctrl_mem_wen;
            mem_addr   <= {ctrl_mem_addr[31:2], 2'b00};
            mem_wdata  <= st_wdata_rep;
            mem_ben    <= st_ben;
            acc_off    <= ctrl_mem_addr[1:0];
            acc_size   <= ctrl_mem_size;
            acc_signed <= ctrl_mem_signed;
            acc_err    <= st_misaligned;
          end
        end
        ST_REQ: begin
          if (timeout_hit) begin
            mem_req <= 1'b0;
            acc_err <= 1'b1;
          end else if (mem_gnt) begin
            mem_req <= 1'b0;
          end
        end
        ST_RSP: begin
          if (timeout_hit) begin
            acc_err <= 1'b1;
          end else if (mem_rvalid) begin
            raw_rdata <= mem_rdata;
            acc_err   <= mem_err;
          end
        end
        ST_DONE: begin
          ctrl_mem_ready <= 1'b1;
          ctrl_mem_error <= acc_err;
          ctrl_mem_rdata <= (acc_err || mem_wen) ? 32'd0 : ld_data;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rvm_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvm_mem_if
// Purpose  : Scoreboard bench for rvm_mem_if. Stimulus pushes the expected
//            completion (data, error, ready cycle) and a bus-response plan;
//            a bus responder follows the plan and checks bus fields; a
//            monitor pops and compares on every ready pulse.
// Options  : RVM_MEM_TIMEOUT_EN selects the expected timeout behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvm_mem_if;

  localparam int TB_TO = 8;

  logic        clk;
  logic        resetn;
  logic        ctrl_mem_req;
  logic        ctrl_mem_wen;
  logic [31:0] ctrl_mem_addr;
  logic [31:0] ctrl_mem_wdata;
  logic [1:0]  ctrl_mem_size;
  logic        ctrl_mem_signed;
  logic        ctrl_mem_ready;
  logic [31:0] ctrl_mem_rdata;
  logic        ctrl_mem_error;
  logic        ctrl_mem_busy;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_ben;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;

  rvm_mem_if #(.TIMEOUT_CYCLES(TB_TO)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .ctrl_mem_req    (ctrl_mem_req),
    .ctrl_mem_wen    (ctrl_mem_wen),
    .ctrl_mem_addr   (ctrl_mem_addr),
    .ctrl_mem_wdata  (ctrl_mem_wdata),
    .ctrl_mem_size   (ctrl_mem_size),
    .ctrl_mem_signed (ctrl_mem_signed),
    .ctrl_mem_ready  (ctrl_mem_ready),
    .ctrl_mem_rdata  (ctrl_mem_rdata),
    .ctrl_mem_error  (ctrl_mem_error),
    .ctrl_mem_busy   (ctrl_mem_busy),
    .mem_req         (mem_req),
    .mem_gnt         (mem_gnt),
    .mem_wen         (mem_wen),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_ben         (mem_ben),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata),
    .mem_err         (mem_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ben;
    logic        wen;
    int          gd;
    int          rd;
    int          extra;
    bit          stray;
    bit          never;
    logic [31:0] rdata;
    logic        err;
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- completion monitor ----------------
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && ctrl_mem_ready) begin
        chk("scoreboard holds an entry at ready", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("ctrl_mem_rdata", ctrl_mem_rdata, e.rdata);
          chk("ctrl_mem_error", 32'(ctrl_mem_error), 32'(e.err));
          chk("ready cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  // ---------------- bus responder ----------------
  task automatic chk_bus(input plan_t p);
    chk("mem_req held", 32'(mem_req), 32'd1);
    chk("mem_addr", mem_addr, p.addr);
    chk("mem_ben", 32'(mem_ben), 32'(p.ben));
    chk("mem_wen", 32'(mem_wen), 32'(p.wen));
    if (p.wen) chk("mem_wdata", mem_wdata, p.wdata);
  endtask

  initial begin : rsp
    plan_t p;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    mem_err    = 1'b0;
    @(negedge clk); #1;
    forever begin
      while (!mem_req) begin @(negedge clk); #1; end
      chk("plan exists for mem_req", 32'(plan_q.size() != 0), 32'd1);
      if (plan_q.size() == 0) begin
        while (mem_req) begin @(negedge clk); #1; end
        continue;
      end
      p = plan_q.pop_front();
      if (p.never) begin
        chk_bus(p);
        while (mem_req) begin @(negedge clk); #1; end
        continue;
      end
      for (int k = 0; k <= p.gd; k++) begin
        chk_bus(p);
        if (k == p.gd) begin
          mem_gnt    = 1'b1;
          mem_rvalid = 1'b0;
        end else if (p.stray && k == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = $urandom;
          mem_err    = 1'b1;
        end else begin
          mem_rvalid = 1'b0;
          mem_err    = 1'b0;
        end
        @(negedge clk); #1;
      end
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_err    = 1'b0;
      chk("mem_req dropped after grant", 32'(mem_req), 32'd0);
      for (int k = 1; k < p.rd; k++) begin @(negedge clk); #1; end
      mem_rvalid = 1'b1;
      mem_rdata  = p.rdata;
      mem_err    = p.err;
      @(negedge clk); #1;
      for (int k = 0; k < p.extra; k++) begin
        mem_rdata = ~p.rdata;
        mem_err   = ~p.err;
        @(negedge clk); #1;
      end
      mem_rvalid = 1'b0;
      mem_err    = 1'b0;
    end
  end

  // ---------------- stimulus + reference model ----------------
  task automatic wait_done();
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk); #1;
      k++;
    end
    chk("access completes in budget", 32'(exp_q.size()), 32'd0);
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  task automatic drive(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic sgn);
    ctrl_mem_wen    = wen;
    ctrl_mem_addr   = addr;
    ctrl_mem_wdata  = wdata;
    ctrl_mem_size   = size;
    ctrl_mem_signed = sgn;
    ctrl_mem_req    = 1'b1;
  endtask

  task automatic access(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic sgn, input int gd, input int rd,
                        input int extra, input bit stray, input logic [31:0] rdata,
                        input logic err, input int hold);
    int          n;
    int          off;
    bit          illegal;
    plan_t       p;
    exp_t        e;
    logic [31:0] v;
    logic [31:0] mask;
    n       = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off     = int'(addr % 4);
    illegal = (size == 2'd3) || ((addr % n) != 0);
    p.addr  = addr - 32'(off);
    p.wen   = wen;
    p.ben   = '0;
    p.wdata = '0;
    v       = '0;
    if (!illegal) begin
      for (int i = 0; i < n; i++) begin
        p.ben[off+i] = 1'b1;
        v = v | (32'(rdata[8*(off+i) +: 8]) << (8*i));
      end
    end
    for (int j = 0; j < 4; j++) p.wdata[8*j +: 8] = wdata[8*(j%n) +: 8];
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 32'd1);
    if (sgn && n < 4 && v[8*n-1]) v = v | ~mask;
    p.gd = gd; p.rd = rd; p.extra = extra; p.stray = stray; p.never = 1'b0;
    p.rdata = rdata; p.err = err;
    e.rdata = (illegal || err || wen) ? 32'd0 : v;
    e.err   = illegal || err;
    e.cyc   = cyc + 1 + (illegal ? 1 : 2 + gd + rd);
    if (!illegal) plan_q.push_back(p);
    exp_q.push_back(e);
    drive(wen, addr, wdata, size, sgn);
    repeat (hold) @(posedge clk);
    #1;
    ctrl_mem_req = 1'b0;
    wait_done();
  endtask

  initial begin : stim
    plan_t       p;
    exp_t        e;
    logic [1:0]  sz;
    logic [31:0] a;
    int          n;

    resetn          = 1'b0;
    ctrl_mem_req    = 1'b0;
    ctrl_mem_wen    = 1'b0;
    ctrl_mem_addr   = '0;
    ctrl_mem_wdata  = '0;
    ctrl_mem_size   = '0;
    ctrl_mem_signed = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset ctrl_mem_ready", 32'(ctrl_mem_ready), 32'd0);
    chk("reset ctrl_mem_rdata", ctrl_mem_rdata, 32'd0);
    chk("reset ctrl_mem_error", 32'(ctrl_mem_error), 32'd0);
    chk("reset ctrl_mem_busy", 32'(ctrl_mem_busy), 32'd0);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset mem_wen", 32'(mem_wen), 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset mem_ben", 32'(mem_ben), 32'd0);
    resetn = 1'b1;
    @(negedge clk); #1;

    // Signed byte load from the top lane, minimum latency.
    access(1'b0, 32'h0000_1003, 32'h0, 2'd0, 1'b1, 0, 1, 0, 1'b0, 32'h80FF_FFFF, 1'b0, 1);
    // Half store to upper lanes with a 3-cycle grant delay.
    access(1'b1, 32'h0000_2002, 32'h1234_ABCD, 2'd1, 1'b0, 3, 1, 0, 1'b0, 32'h0, 1'b0, 1);
    // Misaligned word load: no bus activity.
    access(1'b0, 32'h0000_3001, 32'h0, 2'd2, 1'b0, 0, 1, 0, 1'b0, 32'h0, 1'b0, 1);
    // Bus error on a word load.
    access(1'b0, 32'h0000_3000, 32'h0, 2'd2, 1'b0, 1, 2, 0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1);
    // Illegal size code, then an unsigned half load back to back.
    access(1'b0, 32'h0000_0004, 32'h0, 2'd3, 1'b0, 0, 1, 0, 1'b0, 32'h0, 1'b0, 2);
    access(1'b0, 32'h0000_0006, 32'h0, 2'd1, 1'b0, 0, 1, 2, 1'b1, 32'h8001_7FFF, 1'b0, 1);

    // Reset while waiting for the response.
    p.addr = 32'h0000_4000; p.wdata = '0; p.ben = 4'hF; p.wen = 1'b0;
    p.gd = 0; p.rd = 6; p.extra = 0; p.stray = 1'b0; p.never = 1'b0;
    p.rdata = 32'h5555_AAAA; p.err = 1'b0;
    plan_q.push_back(p);
    drive(1'b0, 32'h0000_4000, 32'h0, 2'd2, 1'b0);
    @(posedge clk); #1;
    ctrl_mem_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy while in RSP", 32'(ctrl_mem_busy), 32'd1);
    resetn = 1'b0;
    #1;
    chk("mem_req after async reset", 32'(mem_req), 32'd0);
    chk("busy after async reset", 32'(ctrl_mem_busy), 32'd0);
    @(negedge clk); #1;
    resetn = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    chk("idle after late rvalid", 32'(ctrl_mem_busy), 32'd0);
    chk("responder consumed plan", 32'(plan_q.size()), 32'd0);
    access(1'b1, 32'h0000_4001, 32'h0000_00A5, 2'd0, 1'b0, 0, 1, 0, 1'b0, 32'h0, 1'b0, 1);

    // Randomized accesses.
    for (int t = 0; t < 150; t++) begin
      sz = 2'($urandom_range(0, 3));
      n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
      access(1'($urandom), a, $urandom, sz, 1'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
             int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0),
             $urandom, ($urandom_range(0, 7) == 0), int'($urandom_range(1, 2)));
    end

    // Grant never arrives.
    p.addr = 32'h0000_8000; p.wdata = '0; p.ben = 4'hF; p.wen = 1'b0;
    p.gd = 0; p.rd = 1; p.extra = 0; p.stray = 1'b0; p.never = 1'b1;
    p.rdata = '0; p.err = 1'b0;
    plan_q.push_back(p);
`ifdef RVM_MEM_TIMEOUT_EN
    e.rdata = '0; e.err = 1'b1; e.cyc = cyc + 1 + TB_TO + 1;
    exp_q.push_back(e);
    drive(1'b0, 32'h0000_8000, 32'h0, 2'd2, 1'b0);
    @(posedge clk); #1;
    ctrl_mem_req = 1'b0;
    wait_done();
    chk("mem_req dropped after timeout", 32'(mem_req), 32'd0);
`else
    drive(1'b0, 32'h0000_8000, 32'h0, 2'd2, 1'b0);
    @(posedge clk); #1;
    ctrl_mem_req = 1'b0;
    repeat (1000) @(negedge clk);
    #1;
    chk("still busy without grant", 32'(ctrl_mem_busy), 32'd1);
    chk("mem_req still held", 32'(mem_req), 32'd1);
`endif
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    chk("plans drained", 32'(plan_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
